pipe_ex_cond: RTL and testbench

PIPE_EX_COND -- requirements
Module: pipe_ex_cond

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_cond_check.sv | 43 ++++
 rtl/pipe_ex_cond.sv | 106 ++++++++++
 tb/tb_pipe_ex_cond.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the EX-stage condition / EX-MEM register slice.
//   cond_t      : the sixteen ARM condition codes.
//   FLAG_*      : bit positions of N, Z, C, V inside a {N,Z,C,V} flag vector.
//   FW_*        : bit positions inside flag_write_e (NZ pair, CV pair).
package pipe_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // flag_write_e[1] updates N,Z ; flag_write_e[0] updates C,V
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/pipe_cond_check.sv
// Combinational ARM condition-code evaluator.
//   cond  : 4-bit condition field
//   flags : {N,Z,C,V}
//   pass  : 1 when the condition holds for these flags
module pipe_cond_check
    import pipe_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b1;
        unique case (cond_t'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ex_cond.sv
// EX-stage conditional execution and EX/MEM pipeline register.
// Evaluates the EX instruction's condition against the architectural flags,
// updates the flags selectively, and registers data/controls into MEM.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   valid_e, cond_e, flag_write_e : EX instruction validity, condition, flag-update mask
//   alu_flags_e, alu_result_e,
//   write_data_e, wa3_e           : EX ALU outputs, store data, destination index
//   reg_write_e, mem_write_e,
//   mem_to_reg_e, branch_e        : decoded EX controls
//   stall_m, flush_m              : hold / kill into MEM (stall wins)
//   cond_pass_e, branch_taken_e   : combinational condition result / branch decision
//   carry_q, flags_q              : registered C flag and {N,Z,C,V}
//   *_m                           : registered MEM-stage data and gated controls
module pipe_ex_cond
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_e,
    input  logic [3:0]  cond_e,
    input  logic [1:0]  flag_write_e,
    input  logic [3:0]  alu_flags_e,
    input  logic [31:0] alu_result_e,
    input  logic [31:0] write_data_e,
    input  logic [3:0]  wa3_e,
    input  logic        reg_write_e,
    input  logic        mem_write_e,
    input  logic        mem_to_reg_e,
    input  logic        branch_e,
    input  logic        stall_m,
    input  logic        flush_m,
    output logic        cond_pass_e,
    output logic        branch_taken_e,
    output logic        carry_q,
    output logic [3:0]  flags_q,
    output logic [31:0] alu_result_m,
    output logic [31:0] write_data_m,
    output logic [3:0]  wa3_m,
    output logic        reg_write_m,
    output logic        mem_write_m,
    output logic        mem_to_reg_m
);

    logic        exec_e;
    logic [1:0]  flag_pair_reg [2];
    logic [31:0] alu_result_reg;
    logic [31:0] write_data_reg;
    logic [3:0]  wa3_reg;
    logic        reg_write_reg;
    logic        mem_write_reg;
    logic        mem_to_reg_reg;

    pipe_cond_check u_cond_check (
        .cond  (cond_e),
        .flags (flags_q),
        .pass  (cond_pass_e)
    );

    // A flushed instruction neither commits flags nor side effects in MEM.
    assign exec_e         = valid_e & cond_pass_e & ~flush_m;
    // Deliberately not qualified by stall_m: the hazard unit owns that.
    assign branch_taken_e = valid_e & branch_e & cond_pass_e;

    // Each flag_write bit owns one flag pair: bit gi controls flags[2*gi+1:2*gi].
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_pair
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                flag_pair_reg[gi] <= 2'b00;
            end else if (!stall_m && exec_e && flag_write_e[gi]) begin
                flag_pair_reg[gi] <= alu_flags_e[2*gi +: 2];
            end
        end
    end

    assign flags_q[FLAG_N:FLAG_Z] = flag_pair_reg[FW_NZ];
    assign flags_q[FLAG_C:FLAG_V] = flag_pair_reg[FW_CV];
    assign carry_q                = flags_q[FLAG_C];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result_reg <= 32'd0;
            write_data_reg <= 32'd0;
            wa3_reg        <= 4'd0;
            reg_write_reg  <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
        end else if (!stall_m) begin
            // Data fields are harmless when the controls are gated off,
            // so they load regardless of condition or flush.
            alu_result_reg <= alu_result_e;
            write_data_reg <= write_data_e;
            wa3_reg        <= wa3_e;
            reg_write_reg  <= reg_write_e  & exec_e;
            mem_write_reg  <= mem_write_e  & exec_e;
            mem_to_reg_reg <= mem_to_reg_e & exec_e;
        end
    end

    assign alu_result_m = alu_result_reg;
    assign write_data_m = write_data_reg;
    assign wa3_m        = wa3_reg;
    assign reg_write_m  = reg_write_reg;
    assign mem_write_m  = mem_write_reg;
    assign mem_to_reg_m = mem_to_reg_reg;

endmodule

// File: tb/tb_pipe_ex_cond.sv
// Self-checking bench for pipe_ex_cond: directed scenarios followed by
// randomized traffic compared against a behavioural model of the flags and
// the EX/MEM register.
module tb_pipe_ex_cond;

    logic        clk;
    logic        reset_n;
    logic        valid_e;
    logic [3:0]  cond_e;
    logic [1:0]  flag_write_e;
    logic [3:0]  alu_flags_e;
    logic [31:0] alu_result_e;
    logic [31:0] write_data_e;
    logic [3:0]  wa3_e;
    logic        reg_write_e;
    logic        mem_write_e;
    logic        mem_to_reg_e;
    logic        branch_e;
    logic        stall_m;
    logic        flush_m;
    logic        cond_pass_e;
    logic        branch_taken_e;
    logic        carry_q;
    logic [3:0]  flags_q;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [3:0]  wa3_m;
    logic        reg_write_m;
    logic        mem_write_m;
    logic        mem_to_reg_m;

    int n_cmp = 0;
    int n_mis = 0;
    int n_txn = 0;

    // Reference state
    logic [3:0]  m_flags;
    logic [31:0] m_alu;
    logic [31:0] m_wd;
    logic [3:0]  m_wa3;
    logic        m_rw;
    logic        m_mw;
    logic        m_mtr;

    pipe_ex_cond dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_e        (valid_e),
        .cond_e         (cond_e),
        .flag_write_e   (flag_write_e),
        .alu_flags_e    (alu_flags_e),
        .alu_result_e   (alu_result_e),
        .write_data_e   (write_data_e),
        .wa3_e          (wa3_e),
        .reg_write_e    (reg_write_e),
        .mem_write_e    (mem_write_e),
        .mem_to_reg_e   (mem_to_reg_e),
        .branch_e       (branch_e),
        .stall_m        (stall_m),
        .flush_m        (flush_m),
        .cond_pass_e    (cond_pass_e),
        .branch_taken_e (branch_taken_e),
        .carry_q        (carry_q),
        .flags_q        (flags_q),
        .alu_result_m   (alu_result_m),
        .write_data_m   (write_data_m),
        .wa3_m          (wa3_m),
        .reg_write_m    (reg_write_m),
        .mem_write_m    (mem_write_m),
        .mem_to_reg_m   (mem_to_reg_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ARM conditions come in complementary pairs: cond[3:1] picks the base
    // predicate, cond[0] inverts it; the last pair always passes.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    task automatic model_reset();
        m_flags = 4'd0; m_alu = 32'd0; m_wd = 32'd0; m_wa3 = 4'd0;
        m_rw = 1'b0; m_mw = 1'b0; m_mtr = 1'b0;
    endtask

    task automatic set_idle();
        valid_e = 1'b0; cond_e = 4'hE; flag_write_e = 2'b00; alu_flags_e = 4'h0;
        alu_result_e = 32'd0; write_data_e = 32'd0; wa3_e = 4'd0;
        reg_write_e = 1'b0; mem_write_e = 1'b0; mem_to_reg_e = 1'b0; branch_e = 1'b0;
        stall_m = 1'b0; flush_m = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".flags_q"},      {28'd0, flags_q},      {28'd0, m_flags});
        check({tag, ".carry_q"},      {31'd0, carry_q},      {31'd0, m_flags[1]});
        check({tag, ".alu_result_m"}, alu_result_m,          m_alu);
        check({tag, ".write_data_m"}, write_data_m,          m_wd);
        check({tag, ".wa3_m"},        {28'd0, wa3_m},        {28'd0, m_wa3});
        check({tag, ".reg_write_m"},  {31'd0, reg_write_m},  {31'd0, m_rw});
        check({tag, ".mem_write_m"},  {31'd0, mem_write_m},  {31'd0, m_mw});
        check({tag, ".mem_to_reg_m"}, {31'd0, mem_to_reg_m}, {31'd0, m_mtr});
    endtask

    // One clock: check EX combinational outputs, advance the model at the edge,
    // then check the registered outputs just after the edge.
    task automatic step(input string tag);
        logic pass, ex;
        @(negedge clk);
        pass = ref_pass(cond_e, m_flags);
        check({tag, ".cond_pass_e"},    {31'd0, cond_pass_e},    {31'd0, pass});
        check({tag, ".branch_taken_e"}, {31'd0, branch_taken_e}, {31'd0, valid_e & branch_e & pass});
        ex = valid_e & pass & ~flush_m;
        @(posedge clk);
        if (!stall_m) begin
            if (ex && flag_write_e[1]) m_flags[3:2] = alu_flags_e[3:2];
            if (ex && flag_write_e[0]) m_flags[1:0] = alu_flags_e[1:0];
            m_alu = alu_result_e; m_wd = write_data_e; m_wa3 = wa3_e;
            m_rw  = reg_write_e & ex; m_mw = mem_write_e & ex; m_mtr = mem_to_reg_e & ex;
        end
        #1;
        n_txn++;
        $display("txn %0d %s: v=%0b cond=%h fw=%b af=%h st=%0b fl=%0b -> flags=%h rw=%0b mw=%0b",
                 n_txn, tag, valid_e, cond_e, flag_write_e, alu_flags_e, stall_m, flush_m,
                 flags_q, reg_write_m, mem_write_m);
        check_regs(tag);
    endtask

    task automatic randomize_inputs();
        valid_e      = ($urandom_range(0, 9) < 8);
        cond_e       = 4'($urandom_range(0, 15));
        flag_write_e = 2'($urandom_range(0, 3));
        alu_flags_e  = 4'($urandom_range(0, 15));
        alu_result_e = $urandom;
        write_data_e = $urandom;
        wa3_e        = 4'($urandom_range(0, 15));
        reg_write_e  = 1'($urandom_range(0, 1));
        mem_write_e  = 1'($urandom_range(0, 1));
        mem_to_reg_e = 1'($urandom_range(0, 1));
        branch_e     = 1'($urandom_range(0, 1));
        stall_m      = ($urandom_range(0, 9) < 2);
        flush_m      = ($urandom_range(0, 9) < 2);
    endtask

    initial begin
        set_idle();
        model_reset();
        reset_n = 1'b0;
        #12;
        check_regs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // EQ fails / NE passes on cleared flags
        valid_e = 1'b1; cond_e = 4'b0000;
        step("eq_reset");
        check("eq_reset.pass_const", {31'd0, cond_pass_e}, 32'd0);
        cond_e = 4'b0001;
        #1 check("ne_reset.pass_const", {31'd0, cond_pass_e}, 32'd1);
        step("ne_reset");

        // SUBS setting N=0,Z=1,C=1,V=0, then EQ write commits
        cond_e = 4'hE; flag_write_e = 2'b11; alu_flags_e = 4'b0110;
        step("subs");
        check("subs.flags_const", {28'd0, flags_q}, 32'h6);
        check("subs.carry_const", {31'd0, carry_q}, 32'd1);
        set_idle(); valid_e = 1'b1; cond_e = 4'b0000; reg_write_e = 1'b1; wa3_e = 4'd5;
        step("eq_write");
        check("eq_write.rw_const", {31'd0, reg_write_m}, 32'd1);

        // LT on zero flags is squashed, LT on N=1,V=0 commits
        reset_n = 1'b0; #1; model_reset();
        @(negedge clk); reset_n = 1'b1;
        set_idle(); valid_e = 1'b1; cond_e = 4'b1011; mem_write_e = 1'b1;
        step("lt_fail");
        check("lt_fail.mw_const", {31'd0, mem_write_m}, 32'd0);
        set_idle(); valid_e = 1'b1; flag_write_e = 2'b10; alu_flags_e = 4'b1000;
        step("set_n");
        set_idle(); valid_e = 1'b1; cond_e = 4'b1011; mem_write_e = 1'b1;
        step("lt_pass");
        check("lt_pass.mw_const", {31'd0, mem_write_m}, 32'd1);

        // CV-only update from cleared flags
        reset_n = 1'b0; #1; model_reset();
        @(negedge clk); reset_n = 1'b1;
        set_idle(); valid_e = 1'b1; flag_write_e = 2'b01; alu_flags_e = 4'b1111;
        step("cv_only");
        check("cv_only.flags_const", {28'd0, flags_q}, 32'h3);

        // Stall beats flush for two cycles, then flush alone zeroes controls
        set_idle(); valid_e = 1'b1; reg_write_e = 1'b1; mem_to_reg_e = 1'b1; wa3_e = 4'd9;
        alu_result_e = 32'h1234_5678;
        step("pre_stall");
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            valid_e = 1'b1; cond_e = 4'hE; flag_write_e = 2'b11;
            stall_m = 1'b1; flush_m = 1'b1;
            step("stall_flush");
        end
        check("stall_flush.rw_const", {31'd0, reg_write_m}, 32'd1);
        check("stall_flush.alu_const", alu_result_m, 32'h1234_5678);
        stall_m = 1'b0;
        step("flush_only");
        check("flush_only.rw_const", {31'd0, reg_write_m}, 32'd0);

        // Asynchronous reset between edges with a live write in MEM
        set_idle(); valid_e = 1'b1; reg_write_e = 1'b1; flag_write_e = 2'b11; alu_flags_e = 4'hF;
        step("pre_async");
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check("async.rw_const", {31'd0, reg_write_m}, 32'd0);
        check("async.flags_const", {28'd0, flags_q}, 32'd0);
        check_regs("async");
        // Release mid-cycle with a live instruction still in EX
        @(negedge clk); #2 reset_n = 1'b1;
        step("post_release");

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            if (i == 150) begin
                #2 reset_n = 1'b0;
                #1 model_reset();
                check_regs("rand_reset");
                #1 reset_n = 1'b1;
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
